// File: rtl/avalon_wait_ram.sv
// Avalon-MM word memory with a fixed number of wait states per transfer and a
// synchronous preload port for loading instruction words before the CPU runs.
module avalon_wait_ram #(
  parameter int unsigned ADDR_BITS   = 8,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic        waitrequest,
  output logic [31:0] readdata,
  input  logic        inst_input,
  input  logic [7:0]  inst_addr,
  input  logic [31:0] instruction,
  output logic        protocol_error
);

  localparam int unsigned IdxBits = ADDR_BITS - 2;
  localparam int unsigned Words   = 2 ** IdxBits;
  localparam logic [3:0]  WaitInit = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StAck} state_e;

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [IdxBits-1:0]   idx_q, idx_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [3:0]           be_q, be_d;
  logic                 wr_q, wr_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 perr_q, perr_d;
  logic                 pre_we, bus_we;

  logic [31:0] mem [Words];

  logic                 req;
  logic [31:0]          inst_addr_ext;
  logic [IdxBits-1:0]   bus_idx, pre_idx;
  logic                 unused_addr_bits;

  assign req           = read | write;
  assign inst_addr_ext = {24'd0, inst_addr};
  assign bus_idx       = address[ADDR_BITS-1:2];
  assign pre_idx       = inst_addr_ext[ADDR_BITS-1:2];
  // Upper and sub-word address bits alias by design.
  assign unused_addr_bits = ^{address[31:ADDR_BITS], address[1:0],
                              inst_addr_ext[31:ADDR_BITS], inst_addr_ext[1:0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      wr_q    <= 1'b0;
      rdata_q <= 32'd0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
      perr_q  <= perr_d;
    end
  end

  // Memory has no reset; contents survive reset.
  always_ff @(posedge clk) begin
    if (pre_we) begin
      mem[pre_idx] <= instruction;
    end else if (bus_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    wr_d    = wr_q;
    rdata_d = 32'd0;
    perr_d  = perr_q;
    pre_we  = 1'b0;
    bus_we  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (inst_input) begin
          pre_we = 1'b1;
        end else if (req) begin
          idx_d   = bus_idx;
          wdata_d = writedata;
          be_d    = byteenable;
          wr_d    = write;
          if (read && write) perr_d = 1'b1;
          if (WAIT_STATES == 0) begin
            state_d = StAck;
            if (!write) rdata_d = mem[bus_idx];
          end else begin
            state_d = StBusy;
            cnt_d   = WaitInit;
          end
        end
      end
      StBusy: begin
        if (!req) begin
          perr_d  = 1'b1;
          state_d = StIdle;
        end else if (cnt_q == 4'd0) begin
          state_d = StAck;
          if (!wr_q) rdata_d = mem[idx_q];
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StAck: begin
        bus_we  = wr_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    waitrequest    = req && (state_q != StAck);
    readdata       = rdata_q;
    protocol_error = perr_q;
  end

endmodule

// File: tb/tb_avalon_wait_ram.sv
// Randomized bench for avalon_wait_ram: a word-array model with byte-lane merge
// predicts read data, wait-state counts and the sticky error flag.
module tb_avalon_wait_ram;

  localparam int unsigned Ws = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] address, writedata, readdata, instruction;
  logic        read, write, waitrequest, inst_input, protocol_error;
  logic [3:0]  byteenable;
  logic [7:0]  inst_addr;

  // Second instance with no wait states, read-only use.
  logic [31:0] z_address, z_readdata, z_instruction;
  logic        z_read, z_waitrequest, z_inst_input, z_perr;
  logic [7:0]  z_inst_addr;

  logic [31:0] mem_m [64];
  logic        perr_m;
  int          n_total = 0;
  int          n_pass  = 0;

  always #5 clk = ~clk;

  avalon_wait_ram #(.ADDR_BITS(8), .WAIT_STATES(Ws)) dut (
    .clk            (clk),
    .reset          (reset),
    .address        (address),
    .read           (read),
    .write          (write),
    .writedata      (writedata),
    .byteenable     (byteenable),
    .waitrequest    (waitrequest),
    .readdata       (readdata),
    .inst_input     (inst_input),
    .inst_addr      (inst_addr),
    .instruction    (instruction),
    .protocol_error (protocol_error)
  );

  avalon_wait_ram #(.ADDR_BITS(8), .WAIT_STATES(0)) dut0 (
    .clk            (clk),
    .reset          (reset),
    .address        (z_address),
    .read           (z_read),
    .write          (1'b0),
    .writedata      (32'd0),
    .byteenable     (4'hF),
    .waitrequest    (z_waitrequest),
    .readdata       (z_readdata),
    .inst_input     (z_inst_input),
    .inst_addr      (z_inst_addr),
    .instruction    (z_instruction),
    .protocol_error (z_perr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] w);
    @(posedge clk); #1;
    inst_input = 1'b1; inst_addr = a; instruction = w;
    @(posedge clk); #1;
    inst_input = 1'b0;
    mem_m[a[7:2]] = w;
  endtask

  // Full handshake: master holds the request until waitrequest drops.
  task automatic xfer(input logic rd, input logic wr, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] b);
    int          n;
    logic [31:0] exp_rd;
    logic [5:0]  idx;
    idx    = a[7:2];
    exp_rd = wr ? 32'd0 : mem_m[idx];
    @(posedge clk); #1;
    read = rd; write = wr; address = a; writedata = d; byteenable = b;
    n = 0;
    @(negedge clk);
    while (waitrequest && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("wait_cycles", 32'(n), 32'(Ws + 1));
    check("ack_readdata", readdata, exp_rd);
    @(posedge clk); #1;
    read = 1'b0; write = 1'b0;
    @(negedge clk);
    check("post_ack_readdata", readdata, 32'd0);
    if (wr) begin
      for (int i = 0; i < 4; i++) if (b[i]) mem_m[idx][8*i +: 8] = d[8*i +: 8];
    end
    if (rd && wr) perr_m = 1'b1;
    check("protocol_error", 32'(protocol_error), 32'(perr_m));
  endtask

  initial begin
    reset = 1'b0; read = 1'b0; write = 1'b0; address = '0; writedata = '0;
    byteenable = '0; inst_input = 1'b0; inst_addr = '0; instruction = '0;
    z_address = '0; z_read = 1'b0; z_inst_input = 1'b0; z_inst_addr = '0;
    z_instruction = '0; perr_m = 1'b0;
    #12;
    check("reset_waitrequest", 32'(waitrequest), 32'd0);
    check("reset_readdata", readdata, 32'd0);
    check("reset_perr", 32'(protocol_error), 32'd0);
    check("reset0_readdata", z_readdata, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    for (int i = 0; i < 64; i++) preload(8'(i * 4), $urandom);

    // Boot-ROM style fetch through an aliased address.
    preload(8'h04, 32'h24020010);
    xfer(1'b1, 1'b0, 32'hBFC00004, 32'd0, 4'h0);

    // Partial-lane write merge.
    xfer(1'b0, 1'b1, 32'h08, 32'hDEADBEEF, 4'b1111);
    xfer(1'b0, 1'b1, 32'h08, 32'h00001100, 4'b0010);
    xfer(1'b1, 1'b0, 32'h08, 32'd0, 4'h0);
    check("merged_word", mem_m[2], 32'hDEAD11EF);

    for (int k = 0; k < 60; k++) begin
      logic rd, wr;
      wr = 1'($urandom_range(0, 1));
      rd = !wr || ($urandom_range(0, 7) == 0);
      xfer(rd, wr, $urandom, $urandom, 4'($urandom));
    end

    // Zero-wait-state instance: one waitrequest cycle then ACK.
    @(posedge clk); #1;
    z_inst_input = 1'b1; z_inst_addr = 8'h04; z_instruction = 32'h24020010;
    @(posedge clk); #1;
    z_inst_input = 1'b0; z_read = 1'b1; z_address = 32'hBFC00004;
    @(negedge clk);
    check("ws0_wait_first", 32'(z_waitrequest), 32'd1);
    @(negedge clk);
    check("ws0_ack", 32'(z_waitrequest), 32'd0);
    check("ws0_readdata", z_readdata, 32'h24020010);
    @(posedge clk); #1;
    z_read = 1'b0;
    @(negedge clk);
    check("ws0_post_readdata", z_readdata, 32'd0);
    check("ws0_perr", 32'(z_perr), 32'd0);

    // Master abandons a read while the slave is still busy.
    @(posedge clk); #1;
    read = 1'b1; address = 32'h0;
    @(posedge clk); #1;
    read = 1'b0;
    @(negedge clk);
    check("abort_waitrequest", 32'(waitrequest), 32'd0);
    @(negedge clk);
    perr_m = 1'b1;
    check("abort_perr", 32'(protocol_error), 32'd1);
    xfer(1'b0, 1'b1, 32'h10, 32'hCAFEF00D, 4'hF);
    xfer(1'b1, 1'b0, 32'h10, 32'd0, 4'h0);

    // Reset during a write's wait states must drop the write.
    @(posedge clk); #1;
    write = 1'b1; address = 32'h14; writedata = 32'h12345678; byteenable = 4'hF;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    write = 1'b0;
    check("midreset_readdata", readdata, 32'd0);
    check("midreset_perr", 32'(protocol_error), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    perr_m = 1'b0;
    xfer(1'b1, 1'b0, 32'h14, 32'd0, 4'h0);

    // Simultaneous read and write: write wins, error flagged.
    xfer(1'b1, 1'b1, 32'h18, 32'h0BADF00D, 4'hF);
    xfer(1'b1, 1'b0, 32'h18, 32'd0, 4'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/avalon_wait_ram.md
Name: avalon_wait_ram

Overview:
- Avalon-MM slave (responder) memory that answers the CPU's bus master through the `address`/`read`/`write`/`waitrequest`/`byteenable`/`readdata` interface.
- Adds a programmable number of wait states, so CPU stall handling is exercised with long bus latencies.
- Also provides a synchronous preload port, used by testbenches to load instruction words before the CPU fetches.

Parameters:
- ADDR_BITS, 8, number of byte-address bits decoded; memory depth is 2^(ADDR_BITS-2) 32-bit words.
- WAIT_STATES, 2, extra BUSY cycles inserted before each acknowledge; legal range 0..15.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- address  in  32  byte address from master; word index = address[ADDR_BITS-1:2]; upper bits and address[1:0] are ignored (aliasing).
- read  in  1  read request, held by master until waitrequest is low.
- write  in  1  write request, held by master until waitrequest is low.
- writedata  in  32  write data.
- byteenable  in  4  lane enables; byteenable[i] maps to data bits [8i+7:8i].
- waitrequest  out  1  high while the slave is not ready to complete the current request.
- readdata  out  32  read data; valid only in the ACK cycle.
- inst_input  in  1  preload enable.
- inst_addr  in  8  preload byte address; word index = inst_addr[ADDR_BITS-1:2].
- instruction  in  32  preload word.
- protocol_error  out  1  sticky error flag.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, wait counter=0, readdata=0, protocol_error=0.
  - Memory array is NOT cleared.
  - Reset asserted mid-transfer aborts the transfer; no write is committed.
- States: IDLE, BUSY, ACK.
- waitrequest = (read|write) && (state!=ACK); it is 0 when no request is present.
- IDLE:
  - If inst_input=1: commit the preload, stay in IDLE, keep waitrequest high.
  - Else if read|write: latch address, writedata, byteenable and direction.
    - Latched direction is write if write=1 (write has priority), else read.
    - If read&&write both high, set protocol_error.
    - If WAIT_STATES=0, go to ACK; else go to BUSY with counter=WAIT_STATES-1.
- BUSY:
  - If read|write drops, the master has aborted: set protocol_error, go to IDLE, no write is committed.
  - Else if counter==0, go to ACK; else decrement counter.
  - For a read, readdata is loaded from mem[latched index] on the BUSY->ACK edge (or IDLE->ACK edge when WAIT_STATES=0).
- ACK (exactly one cycle, waitrequest=0):
  - For a write: on the ACK edge, write the enabled byte lanes of the latched writedata into mem[latched index]; disabled lanes keep their old value.
  - Return to IDLE; readdata returns to 0.
- Latency: request at cycle 0 gives waitrequest low in cycle WAIT_STATES+1. Minimum transfer is 2 cycles. Back-to-back requests give one idle (waitrequest-high) cycle between ACKs.
- Preload:
  - Synchronous on clk, full 32-bit word, ignores byteenable.
  - Allowed only in IDLE; while inst_input=1 no bus request is accepted.
  - inst_input asserted in BUSY/ACK is ignored until IDLE is re-entered.
- Read-after-write to the same word returns the new data; no forwarding is needed because the write commits before IDLE.
- protocol_error clears only on reset.

Test Plan:
- Reset with WAIT_STATES=2 -> waitrequest=0, readdata=0, protocol_error=0.
- Preload inst_addr=8'h04 with 32'h24020010, then read address 32'hBFC00004 -> waitrequest high for 3 cycles, readdata=32'h24020010 in the ACK cycle, 0 afterwards.
- Write 32'hDEADBEEF with byteenable=4'b1111 to 32'h08, then write 32'h00001100 with byteenable=4'b0010, then read 32'h08 -> 32'hDEAD11EF.
- WAIT_STATES=0 variant: read of preloaded word -> waitrequest=1 for exactly 1 cycle, then ACK.
- Master drops read during BUSY -> protocol_error=1, state returns to IDLE; a following write and read of 32'h10 still completes normally.
- Assert reset=0 during BUSY of a write of 32'h12345678 to 32'h14 -> after release, read 32'h14 returns its prior contents; read&&write together -> write performed, protocol_error=1.
